mc_main_controller: RTL and testbench
=====================================

# mc_main_controller

Main control FSM for the multi-cycle MIPS datapath. Decodes the 6-bit opcode from the instruction register and steps the shared ALU, memory, IR, PC and register file through fetch, decode, execute, memory and write-back one state per clock. Drives the 2-bit `alu_op` consumed by the ALU function decoder, which turns it plus `func` into the 3-bit ALU operation. Supports R-type, lw, sw, beq, j, addi and slti.

## Interface
- No parameters. Opcodes are fixed: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, slti 001010.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26], valid from the ID state onward.
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by `zero`.
- `pc_ld` out 1: `pc_write | (pc_write_cond & zero)`, the PC enable.
- `i_or_d` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write` out 1 each.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = use func, 11 = slt.
- `instr_done` out 1: high in the last state of each instruction.

## Operation
- Moore FSM. Outputs decode from the registered state only. Every output not listed for a state is 0.
- IF: `mem_read`, `ir_write`, `pc_write`, `alu_src_b`=01, `alu_op`=00. Next state is ID.
- ID: `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - lw or sw: MEM_ADR.
  - R-type: R_EX.
  - beq: BEQ.
  - j: JMP.
  - addi or slti: I_EX.
  - any other opcode: IF, with `instr_done` high in ID.
- MEM_ADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`, `i_or_d`. Next state is MEM_WB.
- MEM_WB: `reg_write`, `mem_to_reg`, `reg_dst`=0, `instr_done`. Next state is IF.
- MEM_WR: `mem_write`, `i_or_d`, `instr_done`. Next state is IF.
- R_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state is R_WB.
- R_WB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0, `instr_done`. Next state is IF.
- I_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 for addi, 11 for slti. The opcode is still held in the IR. Next state is I_WB.
- I_WB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0, `instr_done`. Next state is IF.
- BEQ: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`, `pc_src`=01, `instr_done`. Next state is IF.
- JMP: `pc_write`, `pc_src`=10, `instr_done`. Next state is IF.
- State register is 4 bits. Unused encodings go to IF on the next edge, and all outputs are 0 while in them.

## Timing
- Reset:
  - `rst` high clears the state to IF asynchronously.
  - While `rst` is high, every output is forced to 0, including `pc_ld`.
  - The first rising edge after `rst` falls completes the fetch of the instruction at the reset PC.
- CPI in clock cycles:
  - lw: 5.
  - sw, R-type, addi, slti: 4.
  - beq, j: 3.
  - illegal opcode: 2.
- `instr_done` is high for exactly one cycle per instruction. IF always follows it.
- Opcode is sampled only in ID and MEM_ADR/I_EX. Changes to `opcode` in any other state have no effect.
- `zero` affects only `pc_ld`, and only in BEQ.
- Reset asserted mid-instruction aborts it: no further `reg_write` or `mem_write`. Execution resumes at IF.

## Test plan
- Reset with `rst`=1 for 3 cycles → all outputs 0. After release, the first cycle shows IF values: `mem_read`=1, `ir_write`=1, `pc_write`=1, `alu_src_b`=01, `alu_op`=00.
- `opcode`=100011 (lw) → state sequence IF, ID, MEM_ADR, MEM_RD, MEM_WB. `mem_to_reg`=1 and `reg_write`=1 only in cycle 5. `instr_done` high only in cycle 5.
- `opcode`=000000 → `alu_op`=10 in cycle 3, `reg_dst`=1 with `reg_write` in cycle 4. `opcode`=001010 → `alu_op`=11 in cycle 3.
- `opcode`=000100 with `zero`=1 → `pc_ld`=1 and `pc_src`=01 in cycle 3. Repeat with `zero`=0 → `pc_ld`=0. Next cycle is IF in both cases.
- `opcode`=101011 (sw) → `mem_write`=1 with `i_or_d`=1 in cycle 4 only, `reg_write` never high. `opcode`=111111 → back to IF after 2 cycles with no writes.
- Assert `rst` during MEM_RD of a lw → outputs 0 immediately. No `reg_write` occurs, and the FSM is in IF after release.

Source files
------------

// File: rtl/mc_main_controller_if.sv
// Control bus between the multi-cycle MIPS main controller and its datapath.
// The controller takes the master side: it reads opcode/zero and drives every control line.
interface mc_main_controller_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_ld;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       instr_done;

  modport master (
    input  opcode, zero,
    output pc_write, pc_write_cond, pc_ld, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op,
           instr_done
  );

  modport slave (
    output opcode, zero,
    input  pc_write, pc_write_cond, pc_ld, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op,
           instr_done
  );
endinterface

// File: rtl/mc_main_controller.sv
// Moore main control FSM for the multi-cycle MIPS datapath.
// Steps fetch/decode/execute/memory/write-back one state per clock and drives all control lines.
module mc_main_controller (
  input logic                  clk,
  input logic                  rst,
  mc_main_controller_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_I_EX    = 4'd8,
    S_I_WB    = 4'd9,
    S_BEQ     = 4'd10,
    S_JMP     = 4'd11
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_next;
  end

  always_comb begin
    state_next = S_IF;
    case (state)
      S_IF: state_next = S_ID;
      S_ID: begin
        case (bus.opcode)
          OP_LW, OP_SW:     state_next = S_MEM_ADR;
          OP_RTYPE:         state_next = S_R_EX;
          OP_BEQ:           state_next = S_BEQ;
          OP_J:             state_next = S_JMP;
          OP_ADDI, OP_SLTI: state_next = S_I_EX;
          default:          state_next = S_IF;
        endcase
      end
      S_MEM_ADR: state_next = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_next = S_MEM_WB;
      S_R_EX:    state_next = S_R_WB;
      S_I_EX:    state_next = S_I_WB;
      default:   state_next = S_IF;
    endcase
  end

  // Outputs come from the registered state only, and are all held low while rst is asserted
  // even though the state register already reads IF during reset.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_src        = 2'b00;
    bus.alu_op        = 2'b00;
    bus.instr_done    = 1'b0;
    if (!rst) begin
      case (state)
        S_IF: begin
          bus.mem_read  = 1'b1;
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.alu_src_b = 2'b01;
        end
        S_ID: begin
          bus.alu_src_b = 2'b11;
          case (bus.opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI, OP_SLTI: bus.instr_done = 1'b0;
            default:                                                bus.instr_done = 1'b1;
          endcase
        end
        S_MEM_ADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_write  = 1'b1;
          bus.i_or_d     = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_R_EX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_R_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_I_EX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = (bus.opcode == OP_SLTI) ? 2'b11 : 2'b00;
        end
        S_I_WB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_BEQ: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_src        = 2'b01;
          bus.instr_done    = 1'b1;
        end
        S_JMP: begin
          bus.pc_write   = 1'b1;
          bus.pc_src     = 2'b10;
          bus.instr_done = 1'b1;
        end
        default: bus.instr_done = 1'b0;
      endcase
    end
  end

  assign bus.pc_ld = bus.pc_write | (bus.pc_write_cond & bus.zero);

endmodule

// File: tb/tb_mc_main_controller.sv
// Self-checking bench for mc_main_controller: directed and random instruction streams compared
// cycle by cycle against an instruction-level model of the expected control vector.
module tb_mc_main_controller;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   failCount  = 0;

  mc_main_controller_if bus ();

  mc_main_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Control vector layout used for every comparison (18 bits, MSB first).
  function automatic logic [17:0] packCtrl(
    input logic pcw, pcwc, pcld, iod, mr, mw, irw, rw, rdst, m2r, srca,
    input logic [1:0] srcb, pcs, aop, input logic done);
    return {pcw, pcwc, pcld, iod, mr, mw, irw, rw, rdst, m2r, srca, srcb, pcs, aop, done};
  endfunction

  function automatic logic [17:0] getActual();
    return packCtrl(bus.pc_write, bus.pc_write_cond, bus.pc_ld, bus.i_or_d, bus.mem_read,
                    bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                    bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_op, bus.instr_done);
  endfunction

  function automatic int cpiOf(input logic [5:0] op);
    case (op)
      6'b100011:                       return 5;
      6'b101011, 6'b000000,
      6'b001000, 6'b001010:            return 4;
      6'b000100, 6'b000010:            return 3;
      default:                         return 2;
    endcase
  endfunction

  // Expected controls for cycle 'cyc' (0 = fetch) of an instruction with opcode 'op'.
  function automatic logic [17:0] expectedCtrl(input logic [5:0] op, input int cyc, input logic z);
    logic pcw = 0, pcwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rw = 0, rdst = 0, m2r = 0, srca = 0, done = 0;
    logic [1:0] srcb = 2'b00, pcs = 2'b00, aop = 2'b00;
    if (cyc == 0) begin
      mr = 1; irw = 1; pcw = 1; srcb = 2'b01;
    end else if (cyc == 1) begin
      srcb = 2'b11; done = (cpiOf(op) == 2);
    end else begin
      case (op)
        6'b100011, 6'b101011: begin
          if (cyc == 2) begin srca = 1; srcb = 2'b10; end
          else if (op == 6'b101011) begin mw = 1; iod = 1; done = 1; end
          else if (cyc == 3) begin mr = 1; iod = 1; end
          else begin rw = 1; m2r = 1; done = 1; end
        end
        6'b000000: begin
          if (cyc == 2) begin srca = 1; aop = 2'b10; end
          else begin rw = 1; rdst = 1; done = 1; end
        end
        6'b001000, 6'b001010: begin
          if (cyc == 2) begin srca = 1; srcb = 2'b10; aop = (op == 6'b001010) ? 2'b11 : 2'b00; end
          else begin rw = 1; done = 1; end
        end
        6'b000100: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
        default:   begin pcw = 1; pcs = 2'b10; done = 1; end
      endcase
    end
    return packCtrl(pcw, pcwc, pcw | (pcwc & z), iod, mr, mw, irw, rw, rdst, m2r, srca,
                    srcb, pcs, aop, done);
  endfunction

  task automatic checkOutput(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Runs 'ncyc' cycles of one instruction, entered just after the rising edge of its fetch cycle.
  // The real opcode is presented only where it is sampled; elsewhere it is random noise.
  // zeroMode: 0/1 forces zero, 2 randomizes it every cycle.
  task automatic applyStimulus(input logic [5:0] op, input int zeroMode, input int ncyc);
    int n = cpiOf(op);
    for (int cyc = 0; cyc < ncyc && cyc < n; cyc++) begin
      logic z = (zeroMode == 2) ? 1'($urandom) : 1'(zeroMode);
      bus.opcode = (cyc == 1 || cyc == 2) ? op : 6'($urandom);
      bus.zero   = z;
      @(negedge clk);
      checkOutput($sformatf("op%06b_c%0d", op, cyc), getActual(), expectedCtrl(op, cyc, z));
      if (cyc + 1 < n && cyc + 1 < ncyc) begin
        @(posedge clk); #1;
      end
    end
    if (ncyc >= n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] legalOps [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b000010, 6'b001000, 6'b001010};

  initial begin
    rst        = 1'b1;
    bus.opcode = 6'b000000;
    bus.zero   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_hold", getActual(), 18'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(6'b100011, 2, 99);
    applyStimulus(6'b000000, 2, 99);
    applyStimulus(6'b001010, 2, 99);
    applyStimulus(6'b000100, 1, 99);
    applyStimulus(6'b000100, 0, 99);
    applyStimulus(6'b101011, 2, 99);
    applyStimulus(6'b111111, 2, 99);
    applyStimulus(6'b001000, 2, 99);
    applyStimulus(6'b000010, 0, 99);

    // Abort a lw during MEM_RD, then confirm the next instruction starts from fetch.
    applyStimulus(6'b100011, 2, 4);
    #2 rst = 1'b1;
    #1 checkOutput("abort_now", getActual(), 18'd0);
    @(posedge clk); #1;
    checkOutput("abort_hold", getActual(), 18'd0);
    rst = 1'b0;
    applyStimulus(6'b100011, 2, 99);

    for (int i = 0; i < 80; i++) begin
      logic [5:0] op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legalOps[$urandom_range(0, 6)];
      applyStimulus(op, 2, 99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
